// File: rtl/length_prefix_packetizer_pkg.sv
// Shared types and helpers for the length-prefix packetizer.
// Holds the FSM state type, the header beat count helper and the last-beat keep mask.
package stream_pkg;

  typedef enum logic [1:0] {
    GET_LEN = 2'd0,
    PASS    = 2'd1,
    DROP    = 2'd2
  } pktz_state_t;

  // Ceiling division, used to size the header in input beats.
  function automatic int clog2_ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Low ((rem-1) mod axis_bytes)+1 lanes set; lanes above axis_bytes are don't-care.
  function automatic logic [7:0] last_keep(input logic [31:0] rem, input logic [31:0] axis_bytes);
    logic [31:0] n_lanes;
    logic [7:0]  keep;
    n_lanes = ((rem - 32'd1) % axis_bytes) + 32'd1;
    keep    = 8'd0;
    for (int i = 0; i < 8; i++) begin
      keep[i] = (32'(i) < n_lanes);
    end
    return keep;
  endfunction

endpackage

// File: rtl/length_prefix_packetizer_len_header_collector.sv
// Gathers the LEN_BYTES-byte length header from HDR_BEATS input beats.
// o_len is combinational so it is usable on the very beat that completes the header.
module len_header_collector
  import stream_pkg::*;
#(
  parameter int AXIS_BYTES     = 1,
  parameter int LEN_BYTES      = 2,
  parameter int LEN_BIG_ENDIAN = 1
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic                    i_beat,
  input  logic [8*AXIS_BYTES-1:0] i_tdata,
  output logic [8*LEN_BYTES-1:0]  o_len,
  output logic                    o_len_valid
);

  localparam int HDR_BEATS = clog2_ceil_div(LEN_BYTES, AXIS_BYTES);
  localparam int CW = $clog2(HDR_BEATS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(HDR_BEATS - 1);

  logic [CW-1:0]          r_hdr_cnt;
  logic [8*LEN_BYTES-1:0] r_hdr;
  logic [8*LEN_BYTES-1:0] w_bytes;

  // Header byte g (stream order) lives in beat g/AXIS_BYTES, lane g%AXIS_BYTES.
  for (genvar g = 0; g < LEN_BYTES; g++) begin : g_byte
    localparam int BEAT = g / AXIS_BYTES;
    localparam int LANE = g % AXIS_BYTES;
    localparam int POS  = (LEN_BIG_ENDIAN != 0) ? (LEN_BYTES - 1 - g) : g;
    assign w_bytes[8*g +: 8] = (r_hdr_cnt == CW'(BEAT)) ? i_tdata[8*LANE +: 8] : r_hdr[8*g +: 8];
    assign o_len[8*POS +: 8] = w_bytes[8*g +: 8];
  end

  assign o_len_valid = i_beat && (r_hdr_cnt == LAST_CNT);

  // Header byte capture and beat counter.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_hdr_cnt <= {CW{1'b0}};
      r_hdr     <= {(8*LEN_BYTES){1'b0}};
    end else if (i_beat) begin
      r_hdr     <= w_bytes;
      r_hdr_cnt <= o_len_valid ? {CW{1'b0}} : (r_hdr_cnt + CW'(1));
    end
  end

endmodule

// File: rtl/length_prefix_packetizer.sv
// Regenerates tlast/tkeep framing for a length-prefixed byte stream.
// Payload passes through combinationally; oversize packets are consumed and dropped.
module length_prefix_packetizer
  import stream_pkg::*;
#(
  parameter int          AXIS_BYTES     = 1,
  parameter int          LEN_BYTES      = 2,
  parameter int          LEN_BIG_ENDIAN = 1,
  parameter int unsigned MAX_LEN        = 1500
) (
  input  logic                    clk,
  input  logic                    aresetn,
  output logic                    axis_i_tready,
  input  logic                    axis_i_tvalid,
  input  logic [8*AXIS_BYTES-1:0] axis_i_tdata,
  input  logic                    axis_o_tready,
  output logic                    axis_o_tvalid,
  output logic                    axis_o_tlast,
  output logic [AXIS_BYTES-1:0]   axis_o_tkeep,
  output logic [8*AXIS_BYTES-1:0] axis_o_tdata,
  output logic                    err_oversize,
  output logic                    err_zero
);

  localparam int LW = 8 * LEN_BYTES;
  localparam logic [LW-1:0] AB_W      = LW'(AXIS_BYTES);
  localparam logic [LW-1:0] MAX_LEN_W = LW'(MAX_LEN);

  if ((MAX_LEN >> LW) != 0) begin : g_max_len_chk
    $error("MAX_LEN does not fit in the length field");
  end

  pktz_state_t r_state;
  logic [LW-1:0] r_rem;
  logic r_err_oversize;
  logic r_err_zero;
  logic [LW-1:0] w_len;
  logic w_len_valid;
  logic w_in_fire;
  logic w_rem_last;

  assign axis_i_tready = (r_state == PASS) ? axis_o_tready : 1'b1;
  assign axis_o_tvalid = (r_state == PASS) && axis_i_tvalid;
  assign axis_o_tdata  = axis_i_tdata;
  assign w_in_fire     = axis_i_tvalid && axis_i_tready;
  assign w_rem_last    = (r_rem <= AB_W);
  assign axis_o_tlast  = (r_state == PASS) && w_rem_last;
  assign axis_o_tkeep  = w_rem_last ? AXIS_BYTES'(last_keep(32'(r_rem), 32'(AXIS_BYTES)))
                                    : {AXIS_BYTES{1'b1}};
  assign err_oversize  = r_err_oversize;
  assign err_zero      = r_err_zero;

  len_header_collector #(
    .AXIS_BYTES    (AXIS_BYTES),
    .LEN_BYTES     (LEN_BYTES),
    .LEN_BIG_ENDIAN(LEN_BIG_ENDIAN)
  ) u_hdr (
    .clk        (clk),
    .aresetn    (aresetn),
    .i_beat     (w_in_fire && (r_state == GET_LEN)),
    .i_tdata    (axis_i_tdata),
    .o_len      (w_len),
    .o_len_valid(w_len_valid)
  );

  // Framing FSM: header parse, forward or drop, one-cycle error pulses.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= GET_LEN;
      r_rem          <= {LW{1'b0}};
      r_err_oversize <= 1'b0;
      r_err_zero     <= 1'b0;
    end else begin
      r_err_oversize <= 1'b0;
      r_err_zero     <= 1'b0;
      case (r_state)
        GET_LEN: begin
          if (w_len_valid) begin
            if (w_len == {LW{1'b0}}) begin
              r_err_zero <= 1'b1;
            end else if (w_len > MAX_LEN_W) begin
              r_err_oversize <= 1'b1;
              r_rem          <= w_len;
              r_state        <= DROP;
            end else begin
              r_rem   <= w_len;
              r_state <= PASS;
            end
          end
        end
        PASS, DROP: begin
          // In PASS an input transfer is exactly an output transfer.
          if (w_in_fire) begin
            if (w_rem_last) begin
              r_rem   <= {LW{1'b0}};
              r_state <= GET_LEN;
            end else begin
              r_rem <= r_rem - AB_W;
            end
          end
        end
        default: begin
          r_rem   <= {LW{1'b0}};
          r_state <= GET_LEN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_length_prefix_packetizer.sv
// Self-checking bench: two packetizer configurations driven with directed and random
// streams, outputs compared against a packet-level reference model.
module tb_length_prefix_packetizer;

  localparam int A_MAX = 12;
  localparam int B_MAX = 20;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Config A: 1-byte bus, 2-byte big-endian length
  logic a_itv = 1'b0, a_otr = 1'b0;
  logic [7:0] a_itd = 8'h00;
  logic a_itr, a_otv, a_otl, a_eo, a_ez;
  logic [0:0] a_otk;
  logic [7:0] a_otd;

  // Config B: 2-byte bus, 3-byte little-endian length
  logic b_itv = 1'b0, b_otr = 1'b0;
  logic [15:0] b_itd = 16'h0000;
  logic b_itr, b_otv, b_otl, b_eo, b_ez;
  logic [1:0] b_otk;
  logic [15:0] b_otd;

  length_prefix_packetizer #(.AXIS_BYTES(1), .LEN_BYTES(2), .LEN_BIG_ENDIAN(1), .MAX_LEN(A_MAX)) dut_a (
    .clk(clk), .aresetn(aresetn),
    .axis_i_tready(a_itr), .axis_i_tvalid(a_itv), .axis_i_tdata(a_itd),
    .axis_o_tready(a_otr), .axis_o_tvalid(a_otv), .axis_o_tlast(a_otl),
    .axis_o_tkeep(a_otk), .axis_o_tdata(a_otd),
    .err_oversize(a_eo), .err_zero(a_ez));

  length_prefix_packetizer #(.AXIS_BYTES(2), .LEN_BYTES(3), .LEN_BIG_ENDIAN(0), .MAX_LEN(B_MAX)) dut_b (
    .clk(clk), .aresetn(aresetn),
    .axis_i_tready(b_itr), .axis_i_tvalid(b_itv), .axis_i_tdata(b_itd),
    .axis_o_tready(b_otr), .axis_o_tvalid(b_otv), .axis_o_tlast(b_otl),
    .axis_o_tkeep(b_otk), .axis_o_tdata(b_otd),
    .err_oversize(b_eo), .err_zero(b_ez));

  logic [7:0]  a_in[$];
  logic [15:0] b_in[$];
  int a_cycles;

  task automatic add_a_pkt(input int len);
    a_in.push_back(8'(len >> 8));
    a_in.push_back(8'(len));
    for (int k = 0; k < len; k++) a_in.push_back(8'($urandom));
  endtask

  task automatic add_b_pkt(input int len);
    b_in.push_back({8'(len >> 8), 8'(len)});
    b_in.push_back({8'($urandom), 8'(len >> 16)});
    for (int k = 0; k < (len + 1) / 2; k++) b_in.push_back(16'($urandom));
  endtask

  // Model: parse a_in into packets, then stream it through dut_a and score outputs.
  task automatic run_a(input int vpct, input int rpct, input string tag);
    logic [8:0] exp_q[$];
    logic [8:0] e;
    int ez = 0, eo = 0, gz = 0, go = 0;
    int i = 0, len, idx = 0, cyc = 0;
    while (i + 2 <= a_in.size()) begin
      len = (int'(a_in[i]) << 8) + int'(a_in[i+1]);
      i += 2;
      if (len == 0) ez++;
      else if (len > A_MAX) begin eo++; i += len; end
      else begin
        for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), a_in[i+k]});
        i += len;
      end
    end
    while ((idx < a_in.size() || exp_q.size() != 0) && cyc < 2000) begin
      @(negedge clk);
      a_itv = (idx < a_in.size()) && ($urandom_range(99) < vpct);
      a_itd = (idx < a_in.size()) ? a_in[idx] : 8'h00;
      a_otr = ($urandom_range(99) < rpct);
      #1;
      gz += int'(a_ez);
      go += int'(a_eo);
      if (a_otv && a_otr) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL %s spurious beat: got data %h, required no output", tag, a_otd);
        else begin
          e = exp_q.pop_front();
          if ({a_otl, a_otd} !== e || a_otk !== 1'b1)
            $display("FAIL %s beat: got last/data %h keep %b, required %h keep 1", tag, {a_otl, a_otd}, a_otk, e);
          else n_pass++;
        end
      end
      if (a_itv && a_itr) idx++;
      cyc++;
    end
    repeat (2) begin
      @(negedge clk);
      a_itv = 1'b0;
      a_otr = 1'b1;
      #1;
      gz += int'(a_ez);
      go += int'(a_eo);
    end
    a_cycles = cyc;
    n_total++;
    if (cyc >= 2000) $display("FAIL %s timeout: got %0d cycles, required completion", tag, cyc);
    else n_pass++;
    n_total++;
    if (gz !== ez) $display("FAIL %s err_zero count: got %0d, required %0d", tag, gz, ez);
    else n_pass++;
    n_total++;
    if (go !== eo) $display("FAIL %s err_oversize count: got %0d, required %0d", tag, go, eo);
    else n_pass++;
  endtask

  // Model for dut_b: 2-beat header (3 LE bytes + discarded lane), beat-granular payload.
  task automatic run_b(input int vpct, input int rpct, input string tag);
    logic [18:0] exp_q[$];
    logic [18:0] e;
    int ez = 0, eo = 0, gz = 0, go = 0;
    int i = 0, len, nb, idx = 0, cyc = 0;
    while (i + 2 <= b_in.size()) begin
      len = int'(b_in[i][7:0]) + (int'(b_in[i][15:8]) << 8) + (int'(b_in[i+1][7:0]) << 16);
      i += 2;
      nb = (len + 1) / 2;
      if (len == 0) ez++;
      else if (len > B_MAX) begin eo++; i += nb; end
      else begin
        for (int k = 0; k < nb; k++)
          exp_q.push_back({(k == nb - 1), ((k == nb - 1) && (len % 2 == 1)) ? 2'b01 : 2'b11, b_in[i+k]});
        i += nb;
      end
    end
    while ((idx < b_in.size() || exp_q.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      b_itv = (idx < b_in.size()) && ($urandom_range(99) < vpct);
      b_itd = (idx < b_in.size()) ? b_in[idx] : 16'h0000;
      b_otr = ($urandom_range(99) < rpct);
      #1;
      gz += int'(b_ez);
      go += int'(b_eo);
      if (b_otv && b_otr) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL %s spurious beat: got data %h, required no output", tag, b_otd);
        else begin
          e = exp_q.pop_front();
          if ({b_otl, b_otk, b_otd} !== e)
            $display("FAIL %s beat: got last/keep/data %h, required %h", tag, {b_otl, b_otk, b_otd}, e);
          else n_pass++;
        end
      end
      if (b_itv && b_itr) idx++;
      cyc++;
    end
    repeat (2) begin
      @(negedge clk);
      b_itv = 1'b0;
      b_otr = 1'b0;
      #1;
      gz += int'(b_ez);
      go += int'(b_eo);
    end
    n_total++;
    if (cyc >= 3000) $display("FAIL %s timeout: got %0d cycles, required completion", tag, cyc);
    else n_pass++;
    n_total++;
    if (gz !== ez) $display("FAIL %s err_zero count: got %0d, required %0d", tag, gz, ez);
    else n_pass++;
    n_total++;
    if (go !== eo) $display("FAIL %s err_oversize count: got %0d, required %0d", tag, go, eo);
    else n_pass++;
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    a_itv = 1'b1;
    a_otr = 1'b1;
    b_itv = 1'b1;
    b_otr = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if ({a_otv, a_itr, a_eo, a_ez} !== 4'b0100)
      $display("FAIL reset_a: got otv/itr/eo/ez %b, required 0100", {a_otv, a_itr, a_eo, a_ez});
    else n_pass++;
    n_total++;
    if ({b_otv, b_itr, b_eo, b_ez} !== 4'b0100)
      $display("FAIL reset_b: got otv/itr/eo/ez %b, required 0100", {b_otv, b_itr, b_eo, b_ez});
    else n_pass++;
    @(negedge clk);
    a_itv = 1'b0;
    b_itv = 1'b0;
    b_otr = 1'b0;
    aresetn = 1'b1;
  endtask

  task automatic test_back_to_back();
    a_in.delete();
    a_in = '{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h01, 8'hDD};
    run_a(100, 100, "b2b");
    n_total++;
    if (a_cycles !== 8) $display("FAIL b2b_cycles: got %0d, required 8", a_cycles);
    else n_pass++;
  endtask

  task automatic test_oversize();
    logic [7:0] d;
    @(negedge clk);
    a_itv = 1'b1;
    a_itd = 8'h00;
    a_otr = 1'b0;
    @(negedge clk);
    a_itd = 8'h0D;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      d = 8'($urandom);
      a_itd = d;
      #1;
      n_total++;
      if (a_itr !== 1'b1 || a_otv !== 1'b0)
        $display("FAIL drop_hs[%0d]: got itr/otv %b%b, required 10", k, a_itr, a_otv);
      else n_pass++;
      if (k == 0) begin
        n_total++;
        if (a_eo !== 1'b1) $display("FAIL drop_err_pulse: got %b, required 1", a_eo);
        else n_pass++;
      end
    end
    a_in.delete();
    a_in = '{8'h00, 8'h01, 8'h77};
    run_a(100, 100, "after_drop");
  endtask

  task automatic test_zero_length();
    a_in.delete();
    a_in = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h99};
    run_a(100, 100, "zero_len");
  endtask

  task automatic test_little_endian();
    b_in.delete();
    b_in.push_back(16'h0002);
    b_in.push_back(16'h5A00);
    b_in.push_back(16'h2211);
    add_b_pkt(258);
    add_b_pkt(3);
    add_b_pkt(0);
    add_b_pkt(1);
    run_b(100, 100, "le");
  endtask

  task automatic test_reset_mid_packet();
    logic [7:0] pay[10];
    int sent = 0, cyc = 0;
    for (int k = 0; k < 10; k++) pay[k] = 8'($urandom);
    @(negedge clk);
    a_itv = 1'b1;
    a_itd = 8'h00;
    a_otr = 1'b1;
    @(negedge clk);
    a_itd = 8'h0A;
    while (sent < 4 && cyc < 200) begin
      @(negedge clk);
      a_itd = pay[sent];
      a_otr = 1'($urandom_range(1));
      #1;
      if (a_otv && a_otr) begin
        n_total++;
        if (a_otd !== pay[sent] || a_otl !== 1'b0)
          $display("FAIL mid_pkt_beat[%0d]: got %h last %b, required %h last 0", sent, a_otd, a_otl, pay[sent]);
        else n_pass++;
        sent++;
      end
      cyc++;
    end
    @(negedge clk);
    a_itd = pay[4];
    a_otr = 1'($urandom_range(1));
    #1;
    n_total++;
    if (a_otv !== 1'b1) $display("FAIL mid_pkt_valid: got %b, required 1", a_otv);
    else n_pass++;
    aresetn = 1'b0;
    #1;
    n_total++;
    if ({a_otv, a_itr} !== 2'b01) $display("FAIL reset_async: got otv/itr %b, required 01", {a_otv, a_itr});
    else n_pass++;
    @(negedge clk);
    aresetn = 1'b1;
    a_itv = 1'b0;
    a_in.delete();
    add_a_pkt(6);
    add_a_pkt(2);
    run_a(80, 50, "post_reset");
  endtask

  task automatic test_random_a();
    a_in.delete();
    for (int p = 0; p < 30; p++) add_a_pkt(int'($urandom_range(15)));
    run_a(75, 60, "rand_a");
  endtask

  task automatic test_random_b();
    b_in.delete();
    for (int p = 0; p < 25; p++) add_b_pkt(int'($urandom_range(24)));
    run_b(70, 65, "rand_b");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_oversize();
    test_zero_length();
    test_little_endian();
    test_reset_mid_packet();
    test_random_a();
    test_random_b();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/length_prefix_packetizer.md
Name: length_prefix_packetizer

Overview:
- Strips a multi-byte length header from an un-framed AXI-Stream and regenerates packet framing (tlast, tkeep) from that length.
- Generalised framer: parametrised data width, header width and header endianness. Byte-granular last-beat tkeep, zero-length skip, oversize-packet discard with an error pulse.
- Sits between a raw byte-stream source (UART/SPI/loopback) and packet-oriented consumers.

Parameters:
- AXIS_BYTES, 1, data bus width in bytes (1..8).
- LEN_BYTES, 2, length field width in bytes (1..4). Length counts payload bytes.
- LEN_BIG_ENDIAN, 1, 1 = first-received header byte is the MSB; 0 = it is the LSB.
- MAX_LEN, 1500, largest length forwarded. Lengths above this are discarded.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- axis_i_tready  out  1  input ready
- axis_i_tvalid  in  1  input valid
- axis_i_tdata  in  8*AXIS_BYTES  input data; byte lane 0 is first in stream order
- axis_o_tready  in  1  output ready
- axis_o_tvalid  out  1  output valid
- axis_o_tlast  out  1  last beat of packet
- axis_o_tkeep  out  AXIS_BYTES  valid byte lanes
- axis_o_tdata  out  8*AXIS_BYTES  output data
- err_oversize  out  1  one-cycle pulse when a header with length > MAX_LEN is accepted
- err_zero  out  1  one-cycle pulse when a header with length 0 is accepted

Behaviour:
- Reset: one clock, `clk`; reset is asynchronous and active-low on `aresetn`.
  - Assertion immediately forces state to GET_LEN, clears hdr_cnt, rem and the header shift register, and clears err_oversize and err_zero.
  - axis_o_tvalid goes 0 combinationally. An in-flight packet is abandoned; there is no tlast.
  - After deassertion, the first accepted beat is treated as a header.
- Header:
  - Occupies HDR_BEATS = ceil(LEN_BYTES/AXIS_BYTES) input beats.
  - Bytes are taken in stream order, lane 0 first, then the next beat.
  - Bytes beyond LEN_BYTES in the final header beat are discarded. They do not start the payload; the payload always begins on a fresh beat.
- Handshake: no payload buffering; data passes through combinationally with 0 latency.
  - GET_LEN: axis_i_tready = 1, axis_o_tvalid = 0.
  - PASS: axis_i_tready = axis_o_tready, axis_o_tvalid = axis_i_tvalid.
  - DROP: axis_i_tready = 1, axis_o_tvalid = 0.
  - A beat transfers when tvalid and tready are both high on the relevant side.
- State machine:
  - GET_LEN: on each accepted beat, shift header bytes in and increment hdr_cnt. On the beat where hdr_cnt reaches HDR_BEATS-1, the length L is complete:
    - L = 0: pulse err_zero and stay in GET_LEN.
    - L > MAX_LEN: pulse err_oversize, load rem = L, go to DROP.
    - Otherwise: load rem = L, go to PASS.
  - PASS: on each output transfer, rem <= rem - AXIS_BYTES.
    - The transfer with rem <= AXIS_BYTES is last: tlast = 1 and the state returns to GET_LEN.
  - DROP: decrement rem identically. Input is consumed and not forwarded. On the beat with rem <= AXIS_BYTES, return to GET_LEN.
- tlast and tkeep:
  - tlast = (state == PASS) && (rem <= AXIS_BYTES).
  - tkeep is all ones, except on the last beat, where it has the low ((rem-1) mod AXIS_BYTES)+1 bits set.
  - tlast and tkeep are meaningful only while tvalid = 1.
- Width rules:
  - rem is 8*LEN_BYTES bits and never underflows.
  - The comparison with MAX_LEN is unsigned. MAX_LEN must fit in 8*LEN_BYTES bits; an elaboration-time assertion checks this.
- Back-to-back: a header beat may immediately follow a last beat. There are no idle cycles between packets.
- Stalls: holding axis_o_tready low in PASS holds axis_i_tready low, and state is held.

Decomposition:
- Package `stream_pkg`:
  - localparam function `clog2_ceil_div` (used for HDR_BEATS).
  - State typedef `pktz_state_t` {GET_LEN, PASS, DROP}.
  - Function `last_keep(rem, AXIS_BYTES)`.
- Sub-module `len_header_collector`: accumulates LEN_BYTES from HDR_BEATS beats with the endian option, and outputs len plus a len_valid strobe.

Test Plan:
- AXIS_BYTES=1, LEN_BYTES=2, big-endian; stream 00 03 AA BB CC 00 01 DD -> output AA, BB, CC(tlast) then DD(tlast); tkeep = 1 throughout; no idle cycles between packets.
- AXIS_BYTES=4, LEN_BYTES=2, big-endian; header beat {lane0=00, lane1=06, x, x}, then AABBCCDD, EEFF1122 -> two output beats; the second has tlast = 1, tkeep = 0011 and carries EE FF.
- LEN_BIG_ENDIAN=0, AXIS_BYTES=1; header bytes 02 00, then 11 22 -> L = 2; 11, 22(tlast).
- MAX_LEN=4, AXIS_BYTES=1; header 00 05 plus 5 payload bytes, then 00 01 77 -> err_oversize pulses once; the 5 payload bytes are not output; 77(tlast) is output; axis_i_tready stays 1 throughout DROP.
- Header 00 00 then 00 01 99 -> err_zero pulses once; no output for the zero-length packet; 99(tlast) is output.
- Random axis_o_tready toggling during a 10-byte packet, plus aresetn pulsed mid-packet at byte 4 -> tvalid drops the same cycle; after release, the next beat parses as a header and the following packet is framed correctly.
